// File: rtl/jb_ul_dfe_pkg.sv
// Shared types and default sizing for the UL DFE output stage.
package jb_ul_dfe_pkg;

  localparam int UL_N_ANTENNAS = 4;
  localparam int UL_PRECISION  = 16;
  localparam int UL_USER_ID_BW = 2;
  localparam int UL_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    WAIT_MRKR,
    WAIT_ANT0,
    RUN,
    DROP_GRP
  } ul_out_state_t;

  // One IQ sample as carried on tdata: Q in the upper half, I in the lower half.
  typedef struct packed {
    logic [UL_PRECISION-1:0] q;
    logic [UL_PRECISION-1:0] i;
  } iq_sample_t;

endpackage

// File: rtl/jb_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rd_data as soon as it is stored; rd_data is forced to zero when empty.
module jb_sync_fifo_fwft #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic                     clk_1x,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push;
  logic             pop;

  // Pushes into a full buffer are refused so the read side can never be corrupted.
  assign push     = wr_en & (level_reg != LW'(DEPTH));
  assign pop      = rd_en & (level_reg != '0);
  assign rd_valid = (level_reg != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
  assign level    = level_reg;

  // Storage array: written only, never reset, so it maps to distributed RAM.
  always_ff @(posedge clk_1x) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset flushes everything buffered.
  always_ff @(posedge clk_1x) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/jb_ul_dfe_output_stage.sv
// UL DFE output stage: aligns an antenna-interleaved sample stream to the
// frame marker and antenna 0, gates muted/disabled antennas, and buffers
// whole antenna groups for the fronthaul packer.
module jb_ul_dfe_output_stage
  import jb_ul_dfe_pkg::*;
#(
  parameter int N_ANTENNAS = UL_N_ANTENNAS,
  parameter int PRECISION  = UL_PRECISION,
  parameter int USER_ID_BW = UL_USER_ID_BW,
  parameter int FIFO_DEPTH = UL_FIFO_DEPTH
) (
  input  logic                          clk_1x,
  input  logic                          rst,
  input  logic                          clk_x1en,
  input  logic                          ul_frm_mrkr,
  input  logic                          ul_out_en,
  input  logic [N_ANTENNAS-1:0]         ul_stream_en,
  input  logic [N_ANTENNAS-1:0]         ul_ant_mute,
  input  logic                          s_tvalid,
  input  logic [2*PRECISION-1:0]        s_tdata,
  input  logic [USER_ID_BW-1:0]         s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [2*PRECISION-1:0]        m_tdata,
  output logic [USER_ID_BW-1:0]         m_tuser,
  output logic                          m_tlast,
  input  logic                          ovf_clr,
  output logic                          ovf_sticky,
  output logic                          seq_err_sticky,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = 2 * PRECISION;
  localparam int WW    = DW + USER_ID_BW + 1;
  localparam logic [USER_ID_BW-1:0] LAST_ANT = USER_ID_BW'(N_ANTENNAS - 1);

  ul_out_state_t         state_reg, state_next;
  logic [USER_ID_BW-1:0] cnt_reg, cnt_next;
  logic                  grp_err_reg, grp_err_next;
  logic                  ovf_sticky_reg, seq_err_sticky_reg;

  logic                  acc;
  logic [LVL_W-1:0]      free;
  logic                  room;
  logic                  mismatch;
  logic [N_ANTENNAS-1:0] gate_en;
  logic [DW-1:0]         gated_data;
  logic                  wr_en;
  logic [DW-1:0]         wr_tdata;
  logic                  wr_tlast;
  logic                  ovf_set;
  logic                  seq_set;
  logic [WW-1:0]         fifo_rd_data;

  // Per-antenna pass enable: streaming and not muted.
  for (genvar gi = 0; gi < N_ANTENNAS; gi++) begin : g_gate
    assign gate_en[gi] = ul_stream_en[gi] & ~ul_ant_mute[gi];
  end

  assign acc        = clk_x1en & s_tvalid;
  assign free       = LVL_W'(FIFO_DEPTH) - fifo_level;
  assign room       = (free >= LVL_W'(N_ANTENNAS));
  assign mismatch   = (s_tuser != cnt_reg);
  assign gated_data = gate_en[cnt_reg] ? s_tdata : '0;

  // Next-state, group counter and write-side decisions.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    grp_err_next = grp_err_reg;
    wr_en        = 1'b0;
    wr_tdata     = '0;
    wr_tlast     = 1'b0;
    ovf_set      = 1'b0;
    seq_set      = 1'b0;
    unique case (state_reg)
      WAIT_MRKR: begin
        if (ul_frm_mrkr && ul_out_en) state_next = WAIT_ANT0;
      end
      WAIT_ANT0: begin
        if (acc && (s_tuser == '0)) begin
          cnt_next     = USER_ID_BW'(1);
          grp_err_next = 1'b0;
          if (!ul_out_en) begin
            state_next = WAIT_MRKR;
            cnt_next   = '0;
          end else if (room) begin
            wr_en      = 1'b1;
            wr_tdata   = gated_data;
            state_next = RUN;
          end else begin
            ovf_set    = 1'b1;
            state_next = DROP_GRP;
          end
        end
      end
      RUN: begin
        if (acc) begin
          // Space for a whole group is reserved when antenna 0 is due.
          if ((cnt_reg == '0) && !room) begin
            ovf_set    = 1'b1;
            cnt_next   = USER_ID_BW'(1);
            state_next = DROP_GRP;
          end else begin
            wr_en    = 1'b1;
            wr_tdata = mismatch ? '0 : gated_data;
            seq_set  = mismatch;
            if (cnt_reg == LAST_ANT) begin
              wr_tlast     = 1'b1;
              cnt_next     = '0;
              grp_err_next = 1'b0;
              if (!ul_out_en)                   state_next = WAIT_MRKR;
              else if (grp_err_reg || mismatch) state_next = WAIT_ANT0;
            end else begin
              cnt_next     = cnt_reg + 1'b1;
              grp_err_next = grp_err_reg | mismatch;
            end
          end
        end
      end
      DROP_GRP: begin
        if (acc) begin
          if (cnt_reg == LAST_ANT) begin
            cnt_next   = '0;
            state_next = WAIT_ANT0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = WAIT_MRKR;
    endcase
  end

  // FSM, counter and error flag registers.
  always_ff @(posedge clk_1x) begin
    if (rst) begin
      state_reg   <= WAIT_MRKR;
      cnt_reg     <= '0;
      grp_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      grp_err_reg <= grp_err_next;
    end
  end

  // Sticky status bits; a new event wins over a clear in the same cycle.
  always_ff @(posedge clk_1x) begin
    if (rst) begin
      ovf_sticky_reg     <= 1'b0;
      seq_err_sticky_reg <= 1'b0;
    end else begin
      if (ovf_set)      ovf_sticky_reg <= 1'b1;
      else if (ovf_clr) ovf_sticky_reg <= 1'b0;
      if (seq_set)      seq_err_sticky_reg <= 1'b1;
      else if (ovf_clr) seq_err_sticky_reg <= 1'b0;
    end
  end

  assign ovf_sticky     = ovf_sticky_reg;
  assign seq_err_sticky = seq_err_sticky_reg;

  // Tag each entry with the expected antenna index, not the received one.
  jb_sync_fifo_fwft #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_1x   (clk_1x),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  ({cnt_reg, wr_tlast, wr_tdata}),
    .rd_en    (m_tready),
    .rd_valid (m_tvalid),
    .rd_data  (fifo_rd_data),
    .level    (fifo_level)
  );

  assign m_tuser = fifo_rd_data[WW-1 -: USER_ID_BW];
  assign m_tlast = fifo_rd_data[DW];
  assign m_tdata = fifo_rd_data[DW-1:0];

endmodule

// File: tb/tb_jb_ul_dfe_output_stage.sv
// Directed bench for the UL DFE output stage.
module tb_jb_ul_dfe_output_stage;
  import jb_ul_dfe_pkg::*;

  logic        clk_1x = 1'b0;
  logic        rst = 1'b1;
  logic        clk_x1en = 1'b0;
  logic        ul_frm_mrkr = 1'b0;
  logic        ul_out_en = 1'b1;
  logic [3:0]  ul_stream_en = 4'hF;
  logic [3:0]  ul_ant_mute = 4'h0;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [1:0]  s_tuser = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic        m_tlast;
  logic        ovf_clr = 1'b0;
  logic        ovf_sticky;
  logic        seq_err_sticky;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [34:0] out_q[$];

  always #5 clk_1x = ~clk_1x;

  jb_ul_dfe_output_stage dut (
    .clk_1x(clk_1x), .rst(rst), .clk_x1en(clk_x1en), .ul_frm_mrkr(ul_frm_mrkr),
    .ul_out_en(ul_out_en), .ul_stream_en(ul_stream_en), .ul_ant_mute(ul_ant_mute),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
    .seq_err_sticky(seq_err_sticky), .fifo_level(fifo_level)
  );

  // Record every accepted output beat as {tuser, tlast, tdata}.
  always @(negedge clk_1x) begin
    if (m_tvalid && m_tready) out_q.push_back({m_tuser, m_tlast, m_tdata});
  end

  function automatic logic [31:0] mk_iq(input logic [15:0] q, input logic [15:0] i);
    iq_sample_t s;
    s.q = q;
    s.i = i;
    return s;
  endfunction

  task automatic drive(input logic en, input logic [1:0] user, input logic [31:0] data);
    @(negedge clk_1x);
    clk_x1en = en; s_tvalid = 1'b1; s_tuser = user; s_tdata = data;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_1x);
      clk_x1en = 1'b0; s_tvalid = 1'b0;
    end
  endtask

  task automatic pulse_marker;
    @(negedge clk_1x);
    clk_x1en = 1'b0; s_tvalid = 1'b0; ul_frm_mrkr = 1'b1;
    @(negedge clk_1x);
    ul_frm_mrkr = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk_1x);
    rst = 1'b1; clk_x1en = 1'b0; s_tvalid = 1'b0; ul_frm_mrkr = 1'b0;
    repeat (2) @(negedge clk_1x);
    rst = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk_1x);
    #1 m_tready = r;
  endtask

  task automatic test_reset;
    @(negedge clk_1x);
    rst = 1'b1;
    repeat (2) @(negedge clk_1x);
    checks++;
    if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {m_tvalid, m_tdata, m_tuser, m_tlast});
    end
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++;
    if ({ovf_sticky, seq_err_sticky} !== 2'b00) begin
      errors++; $display("FAIL reset_sticky: got %b expected 00", {ovf_sticky, seq_err_sticky});
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic [34:0] exp;
    logic [34:0] got;
    do_reset();
    out_q.delete();
    pulse_marker();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 2'(i % 4), mk_iq(16'h0001, 16'(i)));
      if (i == 0) begin
        @(posedge clk_1x);
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h0001_0000) begin
          errors++; $display("FAIL basic_latency: got valid=%b data=%h expected valid=1 data=00010000", m_tvalid, m_tdata);
        end
      end
    end
    idle(4);
    checks++;
    if (out_q.size() != 32) begin errors++; $display("FAIL basic_count: got %0d expected 32", out_q.size()); end
    for (int i = 0; i < 32; i++) begin
      exp = {2'(i % 4), (i % 4) == 3, mk_iq(16'h0001, 16'(i))};
      got = (i < out_q.size()) ? out_q[i] : 35'h0;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", i, got, exp); end
    end
    $display("test_basic done: %0d beats", out_q.size());
  endtask

  task automatic test_mid_group;
    logic [34:0] exp [4];
    do_reset();
    out_q.delete();
    pulse_marker();
    drive(1'b1, 2'd2, 32'h0000_00A2);
    drive(1'b1, 2'd3, 32'h0000_00A3);
    drive(1'b0, 2'd0, 32'hDEAD_BEEF);   // strobe low: must be ignored
    drive(1'b1, 2'd0, 32'h0000_00B0);
    drive(1'b1, 2'd1, 32'h0000_00B1);
    drive(1'b1, 2'd2, 32'h0000_00B2);
    drive(1'b1, 2'd3, 32'h0000_00B3);
    idle(4);
    exp[0] = {2'd0, 1'b0, 32'h0000_00B0};
    exp[1] = {2'd1, 1'b0, 32'h0000_00B1};
    exp[2] = {2'd2, 1'b0, 32'h0000_00B2};
    exp[3] = {2'd3, 1'b1, 32'h0000_00B3};
    checks++;
    if (out_q.size() != 4) begin errors++; $display("FAIL mid_count: got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++; $display("FAIL mid_beat%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 35'h0, exp[i]);
      end
    end
    $display("test_mid_group done");
  endtask

  task automatic test_gating;
    logic [34:0] exp [4];
    do_reset();
    out_q.delete();
    ul_stream_en = 4'b1011;
    ul_ant_mute  = 4'b0001;
    pulse_marker();
    for (int a = 0; a < 4; a++) drive(1'b1, 2'(a), 32'h1111_0000 | 32'(a));
    idle(4);
    exp[0] = {2'd0, 1'b0, 32'h0};
    exp[1] = {2'd1, 1'b0, 32'h1111_0001};
    exp[2] = {2'd2, 1'b0, 32'h0};
    exp[3] = {2'd3, 1'b1, 32'h1111_0003};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++; $display("FAIL gate_beat%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 35'h0, exp[i]);
      end
    end
    ul_stream_en = 4'hF;
    ul_ant_mute  = 4'h0;
    $display("test_gating done");
  endtask

  task automatic test_overflow;
    logic [34:0] exp;
    int budget;
    do_reset();
    set_ready(1'b0);
    out_q.delete();
    pulse_marker();
    for (int k = 0; k < 20; k++) drive(1'b1, 2'(k % 4), 32'h0002_0000 | 32'(k));
    idle(3);
    checks++;
    if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set: got %b expected 1", ovf_sticky); end
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0002_0000) begin
      errors++; $display("FAIL ovf_hold: got valid=%b data=%h expected 1/00020000", m_tvalid, m_tdata);
    end
    set_ready(1'b1);
    budget = 0;
    while (fifo_level != 0 && budget < 40) begin
      @(negedge clk_1x);
      budget++;
    end
    idle(2);
    checks++;
    if (out_q.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", out_q.size()); end
    for (int k = 0; k < 16; k++) begin
      exp = {2'(k % 4), (k % 4) == 3, 32'h0002_0000 | 32'(k)};
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp) begin
        errors++; $display("FAIL ovf_beat%0d: got %h expected %h", k, (k < out_q.size()) ? out_q[k] : 35'h0, exp);
      end
    end
    @(negedge clk_1x); ovf_clr = 1'b1;
    @(negedge clk_1x); ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_sticky); end
    $display("test_overflow done");
  endtask

  task automatic test_seq_err;
    logic [34:0] exp [8];
    logic [1:0]  seq [10] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    do_reset();
    out_q.delete();
    pulse_marker();
    for (int k = 0; k < 10; k++) drive(1'b1, seq[k], 32'h0003_0000 | 32'(k));
    idle(4);
    exp[0] = {2'd0, 1'b0, 32'h0003_0000};
    exp[1] = {2'd1, 1'b0, 32'h0003_0001};
    exp[2] = {2'd2, 1'b0, 32'h0};
    exp[3] = {2'd3, 1'b1, 32'h0003_0003};
    exp[4] = {2'd0, 1'b0, 32'h0003_0006};
    exp[5] = {2'd1, 1'b0, 32'h0003_0007};
    exp[6] = {2'd2, 1'b0, 32'h0003_0008};
    exp[7] = {2'd3, 1'b1, 32'h0003_0009};
    checks++;
    if (out_q.size() != 8) begin errors++; $display("FAIL seq_count: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        errors++; $display("FAIL seq_beat%0d: got %h expected %h", i, (i < out_q.size()) ? out_q[i] : 35'h0, exp[i]);
      end
    end
    checks++;
    if (seq_err_sticky !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b expected 1", seq_err_sticky); end
    @(negedge clk_1x); ovf_clr = 1'b1;
    @(negedge clk_1x); ovf_clr = 1'b0;
    checks++;
    if (seq_err_sticky !== 1'b0) begin errors++; $display("FAIL seq_clear: got %b expected 0", seq_err_sticky); end
    $display("test_seq_err done");
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_ready(1'b0);
    pulse_marker();
    for (int k = 0; k < 6; k++) drive(1'b1, 2'(k % 4), 32'h0004_0000 | 32'(k));
    idle(2);
    checks++;
    if (fifo_level !== 5'd6) begin errors++; $display("FAIL rstmid_level_pre: got %0d expected 6", fifo_level); end
    @(negedge clk_1x); rst = 1'b1;
    @(posedge clk_1x); #1;
    checks++;
    if (fifo_level !== 5'd0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_flush: got level=%0d valid=%b expected 0/0", fifo_level, m_tvalid);
    end
    @(negedge clk_1x); rst = 1'b0;
    set_ready(1'b1);
    out_q.delete();
    for (int a = 0; a < 4; a++) drive(1'b1, 2'(a), 32'h0005_0000 | 32'(a));
    idle(3);
    checks++;
    if (out_q.size() != 0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_marker: got beats=%0d valid=%b expected 0/0", out_q.size(), m_tvalid);
    end
    pulse_marker();
    for (int a = 0; a < 4; a++) drive(1'b1, 2'(a), 32'h0006_0000 | 32'(a));
    idle(3);
    checks++;
    if (out_q.size() != 4 || out_q[0] !== {2'd0, 1'b0, 32'h0006_0000}) begin
      errors++; $display("FAIL rstmid_resume: got beats=%0d first=%h expected 4 / %h",
                         out_q.size(), (out_q.size() > 0) ? out_q[0] : 35'h0, {2'd0, 1'b0, 32'h0006_0000});
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_group();
    test_gating();
    test_overflow();
    test_seq_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
